// File: rtl/sr_arb_pkg.sv
// Shared types for the set/clear request arbiter: FSM states, grant sides
// and a counter-width helper.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GUARD   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_SET = 1'b0,
        GRANT_CLR = 1'b1
    } grant_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int ctr_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/input_conditioner.sv
// Synchronizer, debounce filter and rising-edge pulse for one asynchronous
// push-button input.
module input_conditioner
    import sr_arb_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    localparam int DEB_W = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       cnt_q;
    logic [DEB_W-1:0]       cnt_d;
    logic                   filt_q;
    logic                   filt_d;
    logic                   filt_prev_q;
    logic                   rise_q;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Debounce: the filtered level only follows after DEBOUNCE_CYCLES consecutive disagreements.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_lvl != filt_q) begin
            if (cnt_q == DEB_LAST) begin
                filt_d = sync_lvl;
                cnt_d  = {DEB_W{1'b0}};
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end else begin
            cnt_d = {DEB_W{1'b0}};
        end
    end

    // Synchronizer chain, filter state and registered rising-edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= {SYNC_STAGES{1'b0}};
            cnt_q       <= {DEB_W{1'b0}};
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], async_i};
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            rise_q      <= filt_q & ~filt_prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sr_request_arbiter_checker.sv
// Protocol properties on the arbiter outputs; bound alongside the arbiter in
// simulation only.
module sr_request_arbiter_checker (
    input logic clk,
    input logic reset,
    input logic S,
    input logic R,
    input logic busy,
    input logic q_model,
    input logic conflict
);

    a_no_illegal_latch: assert property (@(posedge clk) !(S && R));

    a_reset_outputs: assert property (@(posedge clk)
        reset |=> (!S && !R && !busy && !q_model && !conflict));

    a_pulse_implies_busy: assert property (@(posedge clk) (S || R) |-> busy);

endmodule

// File: rtl/sr_request_arbiter.sv
// Conditions set/clear push-buttons and sequences them into fixed-width,
// mutually exclusive S/R pulses for a downstream SR latch.
module sr_request_arbiter
    import sr_arb_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GUARD_CYCLES    = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic clr_in,
    output logic S,
    output logic R,
    output logic busy,
    output logic q_model,
    output logic conflict
);

    localparam int SPAN  = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int CNT_W = ctr_width(SPAN);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    grant_e           last_q;
    grant_e           last_d;
    logic             q_model_q;
    logic             q_model_d;
    logic             set_pend_q;
    logic             set_pend_d;
    logic             clr_pend_q;
    logic             clr_pend_d;
    logic             conflict_q;
    logic             conflict_d;
    logic             s_q;
    logic             r_q;
    logic             busy_q;
    logic             set_take;
    logic             clr_take;
    logic             set_rise;
    logic             clr_rise;

    input_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_set_cond (
        .clk     (clk),
        .reset   (reset),
        .async_i (set_in),
        .rise_o  (set_rise)
    );

    input_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_cond (
        .clk     (clk),
        .reset   (reset),
        .async_i (clr_in),
        .rise_o  (clr_rise)
    );

    // Arbiter next-state: grants, redundant-request drops, pulse and guard timing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        q_model_d = q_model_q;
        set_take  = 1'b0;
        clr_take  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (set_pend_q && clr_pend_q) begin
                    // Tie: alternate sides, latch state is irrelevant here.
                    if (last_q == GRANT_SET) begin
                        state_d  = PULSE_R;
                        clr_take = 1'b1;
                        last_d   = GRANT_CLR;
                    end else begin
                        state_d  = PULSE_S;
                        set_take = 1'b1;
                        last_d   = GRANT_SET;
                    end
                end else if (set_pend_q) begin
                    set_take = 1'b1;
                    if (!q_model_q) begin
                        state_d = PULSE_S;
                        last_d  = GRANT_SET;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (clr_pend_q) begin
                    clr_take = 1'b1;
                    if (q_model_q) begin
                        state_d = PULSE_R;
                        last_d  = GRANT_CLR;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE_S, PULSE_R: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d   = GUARD;
                    cnt_d     = {CNT_W{1'b0}};
                    q_model_d = (state_q == PULSE_S);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Pending flags: a new edge wins over a same-cycle consume so it is never lost.
    always_comb begin
        set_pend_d = (set_pend_q & ~set_take) | set_rise;
        clr_pend_d = (clr_pend_q & ~clr_take) | clr_rise;
        conflict_d = ~set_pend_q & set_pend_d & ~clr_pend_q & clr_pend_d;
    end

    // State register; S/R/busy are decoded from the next state so they are flop outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            last_q     <= GRANT_SET;
            q_model_q  <= 1'b0;
            set_pend_q <= 1'b0;
            clr_pend_q <= 1'b0;
            conflict_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            q_model_q  <= q_model_d;
            set_pend_q <= set_pend_d;
            clr_pend_q <= clr_pend_d;
            conflict_q <= conflict_d;
            s_q        <= (state_d == PULSE_S);
            r_q        <= (state_d == PULSE_R);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign q_model  = q_model_q;
    assign conflict = conflict_q;

endmodule
